fixed_point_accumulator: RTL and testbench
==========================================

FIXED_POINT_ACCUMULATOR -- requirements
Module: fixed_point_accumulator

Interface
REQ-001 Parameter: N_TERMS, default 8, number of terms summed per result; legal range 1..16.
REQ-002 Parameter: WIDTH, default 26, data width in bits; two's complement.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: GlobalReset  input  1  reset, synchronous and active-high.
REQ-005 Port: Clear  input  1  synchronous flush of the partial sum and any held result.
REQ-006 Port: In_valid  input  1  Port1 carries a term this cycle.
REQ-007 Port: Port1  input  WIDTH  signed term, typically the adder stage output.
REQ-008 Port: In_ready  output  1  block accepts a term this cycle.
REQ-009 Port: Output_syn  output  WIDTH  registered, saturated group sum.
REQ-010 Port: Out_valid  output  1  Output_syn holds a valid result.
REQ-011 Port: Out_ready  input  1  downstream consumes the result.
REQ-012 Port: Overflow  output  1  result was clipped; valid while Out_valid=1.

Function
REQ-013 The FSM SHALL have two states, ACCUM and HOLD.
REQ-014 In ACCUM, In_ready=1; in HOLD, In_ready=0.
REQ-015 A term SHALL be accepted only when In_valid=1 and In_ready=1.
REQ-016 The internal accumulator SHALL be WIDTH+4 bits; each accepted term is sign-extended before the add, so no internal wrap occurs for N_TERMS<=16.
REQ-017 A term counter SHALL count 0..N_TERMS-1 and increment on each accepted term.
REQ-018 When the term accepted at edge k is term N_TERMS-1, then at edge k:
- Output_syn SHALL load sat(acc+Port1).
- Overflow SHALL load its clip flag.
- Out_valid SHALL go to 1, the FSM SHALL enter HOLD, and the accumulator and counter SHALL clear to 0.
- Latency is one cycle from the last accepted term.
REQ-019 Saturation SHALL clip to [-2^(WIDTH-1), 2^(WIDTH-1)-1] (WIDTH=26: 0x2000000..0x1FFFFFF); Overflow=1 only when clipping occurred.
REQ-020 In HOLD:
- Output_syn, Overflow and Out_valid SHALL be stable until Out_ready=1.
- In_valid SHALL be ignored.
REQ-021 In HOLD with Out_ready=1 at edge m, Out_valid SHALL be 0 and the FSM SHALL be in ACCUM after edge m; the first new term is accepted at edge m+1 at the earliest.
REQ-022 Out_ready SHALL be ignored in ACCUM.
REQ-023 Clear=1 SHALL take effect at that edge:
- The accumulator and counter SHALL be zeroed, Out_valid and Overflow SHALL be 0, and the FSM SHALL be in ACCUM.
- A simultaneous In_valid term is dropped.
- A held result is discarded.
REQ-024 Gaps in In_valid SHALL NOT affect the sum; the partial sum is retained indefinitely.
REQ-025 With N_TERMS=1, every accepted term SHALL produce a result one cycle later, passed through sat().
REQ-026 Output_syn SHALL retain its last value after Out_valid falls.

Reset
REQ-027 GlobalReset=1 SHALL have priority over Clear and all inputs.
REQ-028 After a GlobalReset=1 edge: Output_syn=0, Out_valid=0, Overflow=0, accumulator=0, counter=0, FSM=ACCUM, In_ready=1.
REQ-029 GlobalReset=1 asserted mid-group or in HOLD SHALL discard all partial and held data.

Verification
REQ-030 Reset: one cycle of GlobalReset=1 -> Output_syn=0, Out_valid=0, Overflow=0, In_ready=1.
REQ-031 N_TERMS=4, Out_ready=1, back-to-back terms 100, 300, 500, 800 -> one cycle later Output_syn=1700, Out_valid=1 for exactly one cycle, Overflow=0.
REQ-032 N_TERMS=4, gapped stimulus:
- Stimulus: 1000, two idle cycles, then 2000, -500, -1 (0x3FFFFFF).
- Required response: Output_syn=2499, Overflow=0.
REQ-033 Saturation, N_TERMS=4:
- Four terms of 0x1FFFFFF -> Output_syn=0x1FFFFFF, Overflow=1.
- Four terms of 0x2000000 -> Output_syn=0x2000000, Overflow=1.
REQ-034 Backpressure:
- Stimulus: Out_ready=0 for 3 cycles after the result, with In_valid=1 and Port1=7 driven throughout.
- During the 3 cycles: Out_valid and Output_syn stable, In_ready=0, the 7s ignored.
- Then Out_ready=1: the next group starts from 0, and four terms of 7 give 28.
REQ-035 Clear and reset mid-group:
- Clear after 2 accepted terms of 50, then four terms of 10 -> 40.
- GlobalReset in HOLD -> Out_valid=0 and Output_syn=0 the next cycle.

Source files
------------

// File: rtl/fixed_point_accumulator.sv
// fixed_point_accumulator
// Sums groups of N_TERMS signed WIDTH-bit terms into a guarded accumulator.
// At the last term of a group it registers the saturated sum, with a clip flag,
// and holds that result until downstream takes it.
// Flow control on both sides is valid/ready. Clear flushes the block
// synchronously. GlobalReset is synchronous and active-high, and it wins
// over every other input.

module fixed_point_accumulator #(
    parameter int N_TERMS = 8,   // terms per result, 1..16
    parameter int WIDTH   = 26   // two's-complement data width
) (
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic             Clear,
    input  logic             In_valid,
    input  logic [WIDTH-1:0] Port1,
    output logic             In_ready,
    output logic [WIDTH-1:0] Output_syn,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic             Overflow
);

    // Four guard bits hold any sum of up to 16 full-scale terms without wrapping.
    localparam int ACC_W = WIDTH + 4;
    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

    // Saturation limits in the accumulator width: +2^(WIDTH-1)-1 and -2^(WIDTH-1).
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{5{1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{5{1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        ACCUM = 1'b0,   // taking terms
        HOLD  = 1'b1    // presenting a result; input side stalled
    } state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q,   acc_d;
    logic        [CNT_W-1:0]  cnt_q,   cnt_d;
    logic        [WIDTH-1:0]  result_q, result_d;
    logic                     ovf_q,   ovf_d;
    logic                     valid_q, valid_d;

    logic signed [ACC_W-1:0]  term_ext;
    logic signed [ACC_W-1:0]  sum;
    logic        [WIDTH-1:0]  sat_sum;
    logic                     sat_clip;
    logic                     accept;
    logic                     last_term;

    // Sign-extend the incoming term and add it to the running partial sum.
    always_comb begin
        term_ext = {{4{Port1[WIDTH-1]}}, Port1};
        sum      = acc_q + term_ext;
    end

    // Clip the full-precision sum to the output range and flag any clipping.
    // NOTE: every signal written here gets a value before any branch, so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        sat_sum  = sum[WIDTH-1:0];
        sat_clip = 1'b0;
        if (sum > SAT_MAX) begin
            sat_sum  = SAT_MAX[WIDTH-1:0];
            sat_clip = 1'b1;
        end else if (sum < SAT_MIN) begin
            sat_sum  = SAT_MIN[WIDTH-1:0];
            sat_clip = 1'b1;
        end
    end

    // Handshake decode: a term is taken only while the FSM is collecting.
    always_comb begin
        In_ready  = (state_q == ACCUM);
        accept    = In_valid && In_ready;
        last_term = (cnt_q == LAST_TERM);
    end

    // Next-state logic for the FSM, the accumulator, the counter and the result.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        valid_d  = valid_q;

        if (Clear) begin
            // Flush: the partial sum and any held result are discarded, and a
            // term offered on this cycle is dropped. Output_syn keeps its value.
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    // Out_ready has no effect here.
                    if (accept) begin
                        if (last_term) begin
                            result_d = sat_sum;
                            ovf_d    = sat_clip;
                            valid_d  = 1'b1;
                            state_d  = HOLD;
                            acc_d    = '0;
                            cnt_d    = '0;
                        end else begin
                            acc_d = sum;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // In_valid has no effect here. The result stays frozen
                    // until it is consumed; Output_syn keeps the value after that.
                    if (Out_ready) begin
                        valid_d = 1'b0;
                        ovf_d   = 1'b0;
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    // State register with a synchronous reset that takes priority over everything else.
    // NOTE: sequential state uses non-blocking assignments, so every register
    // updates from the values it saw before the edge.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state_q  <= ACCUM;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    // Registered outputs.
    always_comb begin
        Output_syn = result_q;
        Out_valid  = valid_q;
        Overflow   = ovf_q;
    end

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Testbench for fixed_point_accumulator (N_TERMS=4, WIDTH=26).
// Stimulus tasks keep a small reference model. When a group completes, they
// push the expected saturated sum and clip flag into a scoreboard queue.
// A monitor pops from the queue each time a new result appears.

module tb_fixed_point_accumulator;

    localparam int N_TERMS = 4;
    localparam int WIDTH   = 26;
    localparam longint MAX_V = (64'sd1 <<< (WIDTH-1)) - 1;
    localparam longint MIN_V = -(64'sd1 <<< (WIDTH-1));

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             ovf;
    } result_t;

    logic             clk = 1'b0;
    logic             GlobalReset = 1'b0;
    logic             Clear = 1'b0;
    logic             In_valid = 1'b0;
    logic [WIDTH-1:0] Port1 = '0;
    logic             In_ready;
    logic [WIDTH-1:0] Output_syn;
    logic             Out_valid;
    logic             Out_ready = 1'b1;
    logic             Overflow;

    fixed_point_accumulator #(.N_TERMS(N_TERMS), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .GlobalReset(GlobalReset),
        .Clear      (Clear),
        .In_valid   (In_valid),
        .Port1      (Port1),
        .In_ready   (In_ready),
        .Output_syn (Output_syn),
        .Out_valid  (Out_valid),
        .Out_ready  (Out_ready),
        .Overflow   (Overflow)
    );

    always #5 clk = ~clk;

    int      n_checks = 0;
    int      n_errors = 0;
    result_t sb_q[$];
    longint  model_acc = 0;
    int      model_cnt = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: sum accepted terms; on the group's last term push the saturated result.
    task automatic model_term(input logic [WIDTH-1:0] v);
        result_t r;
        longint  s;
        s = model_acc + longint'($signed(v));
        model_cnt++;
        if (model_cnt == N_TERMS) begin
            r.ovf = 1'b0;
            if (s > MAX_V) begin
                s = MAX_V;
                r.ovf = 1'b1;
            end else if (s < MIN_V) begin
                s = MIN_V;
                r.ovf = 1'b1;
            end
            r.sum = s[WIDTH-1:0];
            sb_q.push_back(r);
            model_acc = 0;
            model_cnt = 0;
        end else begin
            model_acc = s;
        end
    endtask

    task automatic model_flush();
        model_acc = 0;
        model_cnt = 0;
    endtask

    // Offer one term; it is accepted at the next rising edge.
    task automatic send_term(input logic [WIDTH-1:0] v);
        @(negedge clk);
        check("in_ready_accum", 64'(In_ready), 64'd1);
        In_valid = 1'b1;
        Port1    = v;
        model_term(v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            In_valid = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        In_valid    = 1'b0;
        GlobalReset = 1'b1;
        @(negedge clk);
        GlobalReset = 1'b0;
        model_flush();
    endtask

    // Monitor: a rising Out_valid marks a new result, which is compared with the scoreboard head.
    initial begin
        logic    ov_before;
        result_t exp_r;
        forever begin
            @(negedge clk);
            ov_before = Out_valid;
            @(posedge clk);
            #1;
            if (Out_valid === 1'b1 && ov_before !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_result", 64'(Output_syn), 64'd0);
                end else begin
                    exp_r = sb_q.pop_front();
                    check("result_sum", 64'(Output_syn), 64'(exp_r.sum));
                    check("result_ovf", 64'(Overflow), 64'(exp_r.ovf));
                end
            end
        end
    end

    initial begin
        // Reset: one cycle of GlobalReset.
        pulse_reset();
        check("rst_output_syn", 64'(Output_syn), 64'd0);
        check("rst_out_valid", 64'(Out_valid), 64'd0);
        check("rst_overflow", 64'(Overflow), 64'd0);
        check("rst_in_ready", 64'(In_ready), 64'd1);

        // Back-to-back group 100+300+500+800 = 1700; Out_valid lasts one cycle.
        Out_ready = 1'b1;
        send_term(26'd100);
        send_term(26'd300);
        send_term(26'd500);
        send_term(26'd800);
        @(negedge clk);
        In_valid = 1'b0;
        check("b2b_valid_high", 64'(Out_valid), 64'd1);
        @(negedge clk);
        check("b2b_valid_one_cycle", 64'(Out_valid), 64'd0);
        check("b2b_output_retained", 64'(Output_syn), 64'd1700);
        check("b2b_ready_again", 64'(In_ready), 64'd1);

        // Gapped group: 1000, two idle cycles, 2000, -500, -1 gives 2499.
        send_term(26'd1000);
        idle(2);
        send_term(26'd2000);
        send_term(-26'sd500);
        send_term(26'h3FFFFFF);
        idle(2);

        // Saturation at both rails.
        for (int i = 0; i < 4; i++) send_term(26'h1FFFFFF);
        idle(2);
        for (int i = 0; i < 4; i++) send_term(26'h2000000);
        idle(2);

        // Backpressure: group 1+2+3+4 = 10 held for 3 cycles while 7s are offered.
        Out_ready = 1'b0;
        send_term(26'd1);
        send_term(26'd2);
        send_term(26'd3);
        send_term(26'd4);
        @(negedge clk);
        Port1 = 26'd7;   // In_valid stays high; these 7s must be ignored in HOLD
        check("bp_hold_valid", 64'(Out_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(Out_valid), 64'd1);
            check("bp_hold_data", 64'(Output_syn), 64'd10);
            check("bp_hold_ovf", 64'(Overflow), 64'd0);
            check("bp_in_ready_low", 64'(In_ready), 64'd0);
        end
        Out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_term(26'd7);
        idle(2);

        // Clear after two terms of 50 (a simultaneous term is dropped), then 4 x 10 = 40.
        send_term(26'd50);
        send_term(26'd50);
        @(negedge clk);
        Clear    = 1'b1;
        In_valid = 1'b1;
        Port1    = 26'd50;
        model_flush();
        @(negedge clk);
        Clear    = 1'b0;
        In_valid = 1'b0;
        check("clr_out_valid", 64'(Out_valid), 64'd0);
        check("clr_in_ready", 64'(In_ready), 64'd1);
        for (int i = 0; i < 4; i++) send_term(26'd10);
        idle(2);

        // Clear while holding a clipped result discards it.
        Out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_term(26'h1FFFFFF);
        idle(1);
        check("hold_ovf_set", 64'(Overflow), 64'd1);
        @(negedge clk);
        Clear = 1'b1;
        @(negedge clk);
        Clear = 1'b0;
        check("clr_hold_valid", 64'(Out_valid), 64'd0);
        check("clr_hold_ovf", 64'(Overflow), 64'd0);
        check("clr_hold_in_ready", 64'(In_ready), 64'd1);

        // GlobalReset while holding: result discarded and Output_syn zeroed.
        for (int i = 0; i < 4; i++) send_term(26'd5);
        idle(2);
        check("hold_before_rst", 64'(Out_valid), 64'd1);
        pulse_reset();
        check("rst_hold_valid", 64'(Out_valid), 64'd0);
        check("rst_hold_output", 64'(Output_syn), 64'd0);
        check("rst_hold_in_ready", 64'(In_ready), 64'd1);
        Out_ready = 1'b1;

        // GlobalReset mid-group: the partial sum is lost; 4 x 1 = 4.
        send_term(26'd9);
        send_term(26'd9);
        pulse_reset();
        for (int i = 0; i < 4; i++) send_term(26'd1);
        idle(3);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
